// File: rtl/crgu_pkg.sv
// Shared state encoding, output bundle and parameter defaults for the CRGU power/clock sequencer.
package crgu_pkg;

  localparam int CRGU_SEQ_CNT_W       = 8;
  localparam int CRGU_OSC_WAIT_DEF    = 16;
  localparam int CRGU_RST_WAIT_DEF    = 4;
  localparam int CRGU_OSC_TIMEOUT_DEF = 200;

  typedef enum logic [2:0] {
    SEQ_OFF      = 3'd0,
    SEQ_OSC_UP   = 3'd1,
    SEQ_RST_REL  = 3'd2,
    SEQ_SLOT_ON  = 3'd3,
    SEQ_RUN      = 3'd4,
    SEQ_STOP_CLK = 3'd5,
    SEQ_STOP_RST = 3'd6,
    SEQ_FAULT    = 3'd7
  } crgu_seq_state_e;

  typedef struct packed {
    logic osc13m_clk_en;
    logic shut_rstn;
    logic slot_clk_en;
    logic data_clk_en;
    logic timer_clk_en;
    logic pmu_fifo_rstn;
    logic seq_busy;
    logic seq_fault;
  } crgu_seq_out_t;

  // Output levels held while resident in a state.
  function automatic crgu_seq_out_t crgu_seq_decode(input crgu_seq_state_e st);
    crgu_seq_out_t o;
    o = '0;
    case (st)
      SEQ_OSC_UP: begin
        o.osc13m_clk_en = 1'b1;
        o.seq_busy      = 1'b1;
      end
      SEQ_RST_REL, SEQ_STOP_CLK: begin
        o.osc13m_clk_en = 1'b1;
        o.shut_rstn     = 1'b1;
        o.seq_busy      = 1'b1;
      end
      SEQ_SLOT_ON: begin
        o.osc13m_clk_en = 1'b1;
        o.shut_rstn     = 1'b1;
        o.slot_clk_en   = 1'b1;
        o.pmu_fifo_rstn = 1'b1;
        o.seq_busy      = 1'b1;
      end
      SEQ_RUN: begin
        o.osc13m_clk_en = 1'b1;
        o.shut_rstn     = 1'b1;
        o.slot_clk_en   = 1'b1;
        o.data_clk_en   = 1'b1;
        o.timer_clk_en  = 1'b1;
        o.pmu_fifo_rstn = 1'b1;
      end
      SEQ_STOP_RST: begin
        o.osc13m_clk_en = 1'b1;
        o.seq_busy      = 1'b1;
      end
      SEQ_FAULT: o.seq_fault = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/crgu_seq_cnt.sv
// Dwell counter for the sequencer: clears on state change, counts when enabled,
// and optionally sticks at all-ones instead of wrapping.
module crgu_seq_cnt
  import crgu_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      inc,
  input  logic                      sat,
  output logic [CRGU_SEQ_CNT_W-1:0] cnt
);

  logic [CRGU_SEQ_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(sat && (&cnt_q))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/crgu_pwr_seq.sv
// Ordered 13 MHz oscillator / shut-domain reset / gate sequencer in the 32 kHz domain.
// Optional oscillator watchdog with FAULT state: define CRGU_PWR_SEQ_WDT_EN.
module crgu_pwr_seq
  import crgu_pkg::*;
#(
  parameter int OSC_WAIT    = CRGU_OSC_WAIT_DEF,
  parameter int RST_WAIT    = CRGU_RST_WAIT_DEF,
  parameter int OSC_TIMEOUT = CRGU_OSC_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       osc_rdy,
  output logic       osc13m_clk_en,
  output logic       shut_rstn,
  output logic       slot_clk_en,
  output logic       data_clk_en,
  output logic       timer_clk_en,
  output logic       pmu_fifo_rstn,
  output logic       seq_busy,
  output logic [2:0] seq_state,
  output logic       seq_fault
);

  localparam logic [CRGU_SEQ_CNT_W-1:0] OSC_WAIT_M1 = CRGU_SEQ_CNT_W'(OSC_WAIT - 1);
  localparam logic [CRGU_SEQ_CNT_W-1:0] RST_WAIT_M1 = CRGU_SEQ_CNT_W'(RST_WAIT - 1);
`ifdef CRGU_PWR_SEQ_WDT_EN
  localparam logic [CRGU_SEQ_CNT_W-1:0] OSC_TIMEOUT_M1 = CRGU_SEQ_CNT_W'(OSC_TIMEOUT - 1);
`endif

  crgu_seq_state_e           state_q, state_d;
  crgu_seq_out_t             out_q, out_d;
  logic [CRGU_SEQ_CNT_W-1:0] cnt;
  logic                      cnt_clr, cnt_inc, cnt_sat;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEQ_OFF: begin
        if (start_req && !stop_req) state_d = SEQ_OSC_UP;
      end
      SEQ_OSC_UP: begin
        if (stop_req) begin
          state_d = SEQ_STOP_CLK;
        end else if (osc_rdy && (cnt >= OSC_WAIT_M1)) begin
          state_d = SEQ_RST_REL;
`ifdef CRGU_PWR_SEQ_WDT_EN
        end else if (!osc_rdy && (cnt == OSC_TIMEOUT_M1)) begin
          state_d = SEQ_FAULT;
`endif
        end
      end
      SEQ_RST_REL: begin
        if (stop_req)                 state_d = SEQ_STOP_CLK;
        else if (cnt == RST_WAIT_M1)  state_d = SEQ_SLOT_ON;
      end
      SEQ_SLOT_ON:  state_d = stop_req ? SEQ_STOP_CLK : SEQ_RUN;
      SEQ_RUN:      if (stop_req) state_d = SEQ_STOP_CLK;
      // Once power-down starts it always completes, whatever the requests do.
      SEQ_STOP_CLK: if (cnt == RST_WAIT_M1) state_d = SEQ_STOP_RST;
      SEQ_STOP_RST: state_d = SEQ_OFF;
      SEQ_FAULT:    if (stop_req) state_d = SEQ_OFF;
      default:      state_d = SEQ_OFF;
    endcase

    // Outputs are registered from the next state so they move with seq_state.
    out_d = crgu_seq_decode(state_d);
`ifndef CRGU_PWR_SEQ_WDT_EN
    out_d.seq_fault = 1'b0;
`endif
  end

  assign cnt_clr = (state_d != state_q);
  assign cnt_inc = (state_q == SEQ_OSC_UP) || (state_q == SEQ_RST_REL) ||
                   (state_q == SEQ_STOP_CLK);
  assign cnt_sat = (state_q == SEQ_OSC_UP);

  crgu_seq_cnt u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .sat (cnt_sat),
    .cnt (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_OFF;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign osc13m_clk_en = out_q.osc13m_clk_en;
  assign shut_rstn     = out_q.shut_rstn;
  assign slot_clk_en   = out_q.slot_clk_en;
  assign data_clk_en   = out_q.data_clk_en;
  assign timer_clk_en  = out_q.timer_clk_en;
  assign pmu_fifo_rstn = out_q.pmu_fifo_rstn;
  assign seq_busy      = out_q.seq_busy;
  assign seq_fault     = out_q.seq_fault;
  assign seq_state     = state_q;

  // The timeout must never cut short the minimum oscillator settle window.
  cfg_timeout_ge_wait: assert property (@(posedge clk) OSC_TIMEOUT >= OSC_WAIT);

endmodule

// File: tb/tb_crgu_pwr_seq.sv
// Directed bench for crgu_pwr_seq: elapsed-time reference model checked every cycle,
// plus hand-computed checkpoints from the power-up/down timelines.
module tb_crgu_pwr_seq;

  localparam int OSC_WAIT    = 4;
  localparam int RST_WAIT    = 2;
  localparam int OSC_TIMEOUT = 10;
`ifdef CRGU_PWR_SEQ_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start_req, stop_req, osc_rdy;
  logic       osc13m_clk_en, shut_rstn, slot_clk_en, data_clk_en, timer_clk_en;
  logic       pmu_fifo_rstn, seq_busy, seq_fault;
  logic [2:0] seq_state;

  int total = 0;
  int bad   = 0;
  int rc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  crgu_pwr_seq #(
    .OSC_WAIT    (OSC_WAIT),
    .RST_WAIT    (RST_WAIT),
    .OSC_TIMEOUT (OSC_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .osc_rdy       (osc_rdy),
    .osc13m_clk_en (osc13m_clk_en),
    .shut_rstn     (shut_rstn),
    .slot_clk_en   (slot_clk_en),
    .data_clk_en   (data_clk_en),
    .timer_clk_en  (timer_clk_en),
    .pmu_fifo_rstn (pmu_fifo_rstn),
    .seq_busy      (seq_busy),
    .seq_state     (seq_state),
    .seq_fault     (seq_fault)
  );

  // Reference: phase number plus cycles spent in the current phase (unbounded int).
  int m_state = 0;
  int m_el    = 0;

  always @(posedge clk) begin : model
    int nxt;
    nxt = m_state;
    if (rst) nxt = 0;
    else begin
      case (m_state)
        0: if (start_req && !stop_req) nxt = 1;
        1: begin
          if (stop_req) nxt = 5;
          else if (osc_rdy && m_el + 1 >= OSC_WAIT) nxt = 2;
          else if (WDT && !osc_rdy && m_el + 1 == OSC_TIMEOUT) nxt = 7;
        end
        2: if (stop_req) nxt = 5; else if (m_el + 1 == RST_WAIT) nxt = 3;
        3: nxt = stop_req ? 5 : 4;
        4: if (stop_req) nxt = 5;
        5: if (m_el + 1 == RST_WAIT) nxt = 6;
        6: nxt = 0;
        7: if (stop_req) nxt = 0;
        default: nxt = 0;
      endcase
    end
    m_el    = (nxt == m_state) ? m_el + 1 : 0;
    m_state = nxt;
  end

  // {osc13m, shut_rstn, slot, data, timer, fifo_rstn, busy, fault}
  function automatic logic [7:0] exp_vec(input int s);
    case (s)
      1:       return 8'b1000_0010;
      2:       return 8'b1100_0010;
      3:       return 8'b1110_0110;
      4:       return 8'b1111_1100;
      5:       return 8'b1100_0010;
      6:       return 8'b1000_0010;
      7:       return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] dut_vec();
    return {osc13m_clk_en, shut_rstn, slot_clk_en, data_clk_en, timer_clk_en,
            pmu_fifo_rstn, seq_busy, seq_fault};
  endfunction

  always @(negedge clk) begin : cmp
    logic [10:0] act, req;
    if (chk_en) begin
      act = {seq_state, dut_vec()};
      req = {3'(m_state), exp_vec(m_state)};
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL model_cmp t=%0t actual=%b required=%b", $time, act, req);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s rel_cycle=%0d actual=%0h required=%0h", name, rc, act, req);
    end
  endtask

  task automatic go(input int t);
    if (t > rc) begin
      repeat (t - rc) @(posedge clk);
      #1;
      rc = t;
    end
  endtask

  task automatic mark();
    rc = 0;
  endtask

  initial begin
    rst = 1'b1; start_req = 1'b0; stop_req = 1'b0; osc_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_outs", dut_vec(), 8'h00);
    chk("reset_state", 8'(seq_state), 8'd0);

    // Power-up with oscillator ready, then power-down from RUN.
    mark();
    rst = 1'b0; start_req = 1'b1;
    go(1);  start_req = 1'b0;
    chk("pu_osc_on", 8'(osc13m_clk_en), 8'd1);
    chk("pu_state1", 8'(seq_state), 8'd1);
    go(4);  chk("pu_shut_low_c4", 8'(shut_rstn), 8'd0);
    go(5);  chk("pu_shut_c5", 8'(shut_rstn), 8'd1);
    go(6);  chk("pu_slot_low_c6", 8'(slot_clk_en), 8'd0);
    go(7);  chk("pu_slot_fifo_c7", {6'd0, slot_clk_en, pmu_fifo_rstn}, 8'd3);
    chk("pu_data_low_c7", 8'(data_clk_en), 8'd0);
    go(8);  chk("pu_data_timer_c8", {6'd0, data_clk_en, timer_clk_en}, 8'd3);
    chk("pu_run_state", {4'd0, seq_busy, seq_state}, 8'd4);
    go(10); stop_req = 1'b1;
    go(11); stop_req = 1'b0;
    chk("pd_gates_off", {4'd0, slot_clk_en, data_clk_en, timer_clk_en, pmu_fifo_rstn}, 8'd0);
    chk("pd_shut_held", {6'd0, shut_rstn, osc13m_clk_en}, 8'd3);
    go(13); chk("pd_shut_drop", {6'd0, shut_rstn, osc13m_clk_en}, 8'd1);
    chk("pd_state6", 8'(seq_state), 8'd6);
    go(14); chk("pd_osc_off", 8'(osc13m_clk_en), 8'd0);
    chk("pd_state0", 8'(seq_state), 8'd0);

    // Abort from RST_REL with start held, then restart from OFF.
    mark();
    start_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      go(c);
      chk("abort_no_data", 8'(data_clk_en), 8'd0);
      if (c == 5) begin
        chk("abort_in_rst_rel", 8'(seq_state), 8'd2);
        stop_req = 1'b1;
      end
      if (c == 6) begin
        stop_req = 1'b0;
        chk("abort_stop_clk", 8'(seq_state), 8'd5);
      end
      if (c == 9) chk("abort_off", {5'd0, seq_state}, 8'd0);
      if (c == 10) chk("abort_restart", 8'(seq_state), 8'd1);
    end
    start_req = 1'b0;

    // Abort from OSC_UP, then start+stop together in OFF, then rst mid-RUN.
    go(11); stop_req = 1'b1;
    go(13); start_req = 1'b1;
    go(15); chk("both_off_c15", 8'(seq_state), 8'd0);
    go(17); chk("both_stay_off", {4'd0, osc13m_clk_en, seq_state}, 8'd0);
    stop_req = 1'b0;
    go(18); chk("both_release", 8'(seq_state), 8'd1);
    start_req = 1'b0;
    go(25); chk("rst_pre_run", 8'(seq_state), 8'd4);
    go(26); rst = 1'b1;
    go(27); chk("rst_outs", dut_vec(), 8'h00);
    chk("rst_state", 8'(seq_state), 8'd0);
    rst = 1'b0;
    go(29);

`ifndef CRGU_PWR_SEQ_WDT_EN
    // Late oscillator.
    mark();
    osc_rdy = 1'b0; start_req = 1'b1;
    go(1);  start_req = 1'b0;
    go(20); chk("late_wait", 8'(seq_state), 8'd1);
    osc_rdy = 1'b1;
    go(21); chk("late_rst_rel", 8'(seq_state), 8'd2);
    go(24); chk("late_run", 8'(seq_state), 8'd4);
    stop_req = 1'b1;
    go(25); stop_req = 1'b0;
    go(30); chk("late_off", 8'(seq_state), 8'd0);

    // Ready arrives after 256 OSC_UP cycles: a wrapped counter would read 0 here.
    mark();
    osc_rdy = 1'b0; start_req = 1'b1;
    go(1);   start_req = 1'b0;
    go(257); chk("sat_wait", 8'(seq_state), 8'd1);
    osc_rdy = 1'b1;
    go(258); chk("sat_no_wrap", 8'(seq_state), 8'd2);
    go(261); chk("sat_run", 8'(seq_state), 8'd4);
    stop_req = 1'b1;
    go(262); stop_req = 1'b0;
    go(266); chk("sat_off", 8'(seq_state), 8'd0);
`else
    // Oscillator timeout into FAULT and recovery via stop_req.
    mark();
    osc_rdy = 1'b0; start_req = 1'b1;
    go(1);  start_req = 1'b0;
    go(10); chk("wdt_osc_up", 8'(seq_state), 8'd1);
    go(11); chk("wdt_fault_state", 8'(seq_state), 8'd7);
    chk("wdt_fault_outs", dut_vec(), 8'h01);
    start_req = 1'b1;
    go(13); chk("wdt_start_ignored", 8'(seq_state), 8'd7);
    start_req = 1'b0; stop_req = 1'b1;
    go(14); chk("wdt_recover", {4'd0, seq_fault, seq_state}, 8'd0);
    stop_req = 1'b0; osc_rdy = 1'b1;
    go(16);
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crgu_pwr_seq.md
# crgu_pwr_seq

Power/clock sequencer for the CRGU, running in the 32 kHz always-on domain. It turns the 13 MHz oscillator on and off in order, releases and asserts the shut-domain reset, and opens and closes the slot, data, timer and FIFO gates. It drives `osc13m_clk_en`, `shut_rstn`, `slot_clk_en`, `data_clk_en`, `timer_clk_en` and `pmu_fifo_rstn` into the CRGU.

## Interface
Parameters:
- `OSC_WAIT`, default 16: minimum 32 kHz cycles spent in OSC_UP. Legal range 1..255.
- `RST_WAIT`, default 4: cycles spent in RST_REL and STOP_CLK. Legal range 1..255.
- `OSC_TIMEOUT`, default 200: OSC_UP cycle limit before a fault. Only used with `CRGU_PWR_SEQ_WDT_EN`. Must be ≥ OSC_WAIT.

Ports:
- `clk` in 1: 32 kHz always-on clock (`clk_32k`).
- `rst` in 1: reset. Synchronous, active-high.
- `start_req` in 1: level request to power up. Already synchronised to `clk`.
- `stop_req` in 1: level request to power down. Already synchronised.
- `osc_rdy` in 1: 13 MHz oscillator settled flag. Already synchronised.
- `osc13m_clk_en` out 1: enables the 13 MHz clock gate.
- `shut_rstn` out 1: shut-domain reset, active-low.
- `slot_clk_en` out 1: timeslot clock enable.
- `data_clk_en` out 1: data clock enable.
- `timer_clk_en` out 1: timer clock enable.
- `pmu_fifo_rstn` out 1: FIFO reset, active-low.
- `seq_busy` out 1: high in any transitional state.
- `seq_state` out 3: current state encoding.
- `seq_fault` out 1: oscillator timeout flag. Tied 0 without the macro.

## Operation
- All outputs are registered and update on the same edge as the state register.
- Reset value: every output is 0, and `seq_state` = OFF.
- States and encodings:
  - OFF = 0: all outputs 0.
  - OSC_UP = 1: `osc13m_clk_en` = 1.
  - RST_REL = 2: adds `shut_rstn` = 1.
  - SLOT_ON = 3: adds `slot_clk_en` = 1 and `pmu_fifo_rstn` = 1.
  - RUN = 4: adds `data_clk_en` = 1 and `timer_clk_en` = 1.
  - STOP_CLK = 5: `osc13m_clk_en` and `shut_rstn` stay 1; all other outputs are 0.
  - STOP_RST = 6: only `osc13m_clk_en` = 1.
  - FAULT = 7: all enables 0, `seq_fault` = 1.
- Transitions:
  - OFF→OSC_UP when `start_req` && !`stop_req`.
  - OSC_UP→RST_REL when cnt ≥ OSC_WAIT−1 && `osc_rdy`.
  - RST_REL→SLOT_ON when cnt == RST_WAIT−1.
  - SLOT_ON→RUN unconditionally after 1 cycle.
  - RUN→STOP_CLK on `stop_req`.
  - STOP_CLK→STOP_RST when cnt == RST_WAIT−1.
  - STOP_RST→OFF after 1 cycle.
- Abort: `stop_req` in OSC_UP, RST_REL or SLOT_ON goes directly to STOP_CLK. Power-down always runs in full.
- `start_req` is ignored outside OFF. If `start_req` is still high on return to OFF, a new power-up starts the next cycle.
- Counter is 8 bits. It clears on every state change and increments in OSC_UP, RST_REL and STOP_CLK. In OSC_UP it saturates at 255 and does not wrap.
- `seq_busy` = 1 in states 1, 2, 3, 5 and 6.

## Timing
- `start_req` sampled high at edge N: `osc13m_clk_en` is high after edge N+1.
- Best-case power-up with `osc_rdy` already high: OFF→RUN takes OSC_WAIT + RST_WAIT + 2 cycles after the request edge.
- Power-down: `stop_req` sampled in RUN → clock enables drop 1 cycle later. `shut_rstn` drops RST_WAIT cycles after that. `osc13m_clk_en` drops 1 cycle later again.
- Ordering guarantees:
  - `shut_rstn` never rises before OSC_WAIT cycles of `osc13m_clk_en`.
  - `data_clk_en` never rises in the same cycle as `shut_rstn`.
  - On power-down, gates always close before `shut_rstn` falls.
- `rst` in any state returns to OFF at the next edge and drops all outputs at once. This is the only non-ordered shutdown.

## Configuration
- Macro: `CRGU_PWR_SEQ_WDT_EN`.
- Defined:
  - In OSC_UP, cnt == OSC_TIMEOUT−1 with `osc_rdy` low → FAULT.
  - FAULT holds `seq_fault` = 1 with all enables 0.
  - FAULT→OFF when `stop_req` is high; `seq_fault` clears at that point.
  - `start_req` is ignored in FAULT.
- Undefined: OSC_UP waits indefinitely for `osc_rdy`. FAULT is unreachable, `seq_fault` is tied 0, and OSC_TIMEOUT is unused.

## Structure
- `crgu_pkg` holds:
  - `crgu_seq_state_e`, a 3-bit enum with the encodings above.
  - `CRGU_SEQ_CNT_W` = 8.
  - Default values for OSC_WAIT, RST_WAIT and OSC_TIMEOUT.
- One sub-module, `crgu_seq_cnt`: 8-bit counter with `clr`, `inc` and `sat` inputs.
- The FSM and output registers stay in `crgu_pwr_seq`.

## Test plan
- Power-up: OSC_WAIT = 4, RST_WAIT = 2, `osc_rdy` = 1, `start_req` pulsed high at cycle 0 → `osc13m_clk_en` at 1, `shut_rstn` at 5, `slot_clk_en` at 7, `data_clk_en` and `timer_clk_en` at 8.
- Late oscillator: `osc_rdy` rises at cycle 20 (OSC_WAIT = 4) → RST_REL entered at cycle 21, and the counter holds saturated-safe with no wrap.
- Power-down from RUN: `stop_req` at cycle T → gates drop at T+1, `shut_rstn` drops at T+3, `osc13m_clk_en` drops at T+4, `seq_state` = 0 at T+4.
- Abort: `stop_req` during RST_REL → STOP_CLK next cycle, `data_clk_en` never rises, full power-down completes. `start_req` held high → restart from OFF one cycle later.
- Simultaneous `start_req` and `stop_req` in OFF → stays OFF. Then `rst` asserted mid-RUN → all outputs 0 at the next edge.
- With `CRGU_PWR_SEQ_WDT_EN`: OSC_TIMEOUT = 10, `osc_rdy` held 0 → FAULT at cycle 11 with `seq_fault` = 1. `stop_req` → OFF and `seq_fault` = 0.
